// File: rtl/sistema_seg_pio.sv
// sistema_seg_pio: multi-channel Avalon-MM output PIO with prescaled hardware blink and phase interrupt.
module sistema_seg_pio #(
  parameter int CHANNELS = 6,
  parameter int WIDTH = 8,
  parameter int PRESCALE_W = 24,
  parameter logic [WIDTH-1:0] BLANK_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      irq
);
  logic [WIDTH-1:0] data [CHANNELS];
  logic [CHANNELS-1:0] mask;
  logic [PRESCALE_W-1:0] period, cnt;
  logic [2:0] ctrl;
  logic phase, pend;
  logic wr, wr_ctrl, wr_per, wr_stat, en, tgl;
  assign wr = chipselect & ~write_n;
  assign wr_ctrl = wr && address == 4'd10;
  assign wr_per = wr && address == 4'd9;
  assign wr_stat = wr && address == 4'd11;
  // enabling takes effect from the next edge, disabling forces PHASE low on the writing edge
  assign en = ctrl[1] && period != '0 && !(wr_ctrl && !writedata[1]);
  assign tgl = en && !wr_per && cnt == period;
  assign irq = pend & ctrl[2];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) data[i] <= '0;
      mask <= '0;
      period <= '0;
      ctrl <= '0;
      cnt <= '0;
      phase <= 1'b0;
      pend <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) if (wr && address == 4'(i)) data[i] <= writedata[WIDTH-1:0];
      if (wr && address == 4'd8) mask <= writedata[CHANNELS-1:0];
      if (wr_per) period <= writedata[PRESCALE_W-1:0];
      if (wr_ctrl) ctrl <= writedata[2:0];
      cnt <= (!en || wr_per || tgl) ? '0 : cnt + PRESCALE_W'(1);
      phase <= en & (phase ^ tgl);
      pend <= tgl | (pend & ~(wr_stat & writedata[1]));
    end
  end
  always_comb begin
    readdata = '0;
    for (int i = 0; i < CHANNELS; i++) if (address == 4'(i)) readdata = 32'(data[i]);
    case (address)
      4'd8: readdata = 32'(mask);
      4'd9: readdata = 32'(period);
      4'd10: readdata = 32'(ctrl);
      4'd11: readdata = {30'b0, pend, phase};
      default: ;
    endcase
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign out_port[g*WIDTH +: WIDTH] = (!ctrl[0] || (ctrl[1] && mask[g] && phase)) ? BLANK_VALUE : data[g];
  end
endmodule

// File: tb/tb_sistema_seg_pio.sv
// tb_sistema_seg_pio: scoreboard bench; stimulus queues expectations, a negedge monitor compares them.
module tb_sistema_seg_pio;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1;
  logic [3:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [47:0] out_port;
  logic irq;
  typedef struct { string name; int sel; logic [63:0] exp; } item_t;
  item_t q[$];
  item_t it;
  logic [63:0] act;
  int total = 0, passed = 0;
  localparam logic [47:0] ALL = 48'h060504030201, BLK = 48'h060504030000;

  sistema_seg_pio dut (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port), .irq(irq));

  always #5 clk = ~clk;

  always @(negedge clk)
    while (q.size() != 0) begin
      it = q.pop_front();
      act = it.sel == 0 ? 64'(readdata) : it.sel == 1 ? 64'(out_port) : 64'(irq);
      total++;
      if (act === it.exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", it.name, act, it.exp);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1;
  endtask
  task automatic exp_out(input string n, input logic [47:0] e);
    q.push_back('{n, 1, 64'(e)});
  endtask
  task automatic exp_irq(input string n, input logic e);
    q.push_back('{n, 2, 64'(e)});
  endtask
  task automatic chk_rd(input string n, input logic [3:0] a, input logic [31:0] e);
    address = a;
    q.push_back('{n, 0, 64'(e)});
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    exp_out("reset_out", 0); exp_irq("reset_irq", 0);
    chk_rd("reset_ctrl", 10, 0);
    reset = 0;
    for (int i = 0; i < 6; i++) wr(4'(i), 32'(i + 1));
    wr(4, 32'hFFFF_FF05);
    exp_out("out_disabled", 0);
    wr(10, 1);
    total++;
    if (out_port === ALL) passed++;
    else $display("FAIL out_enabled_direct: got %0h expected %0h", out_port, ALL);
    exp_out("out_enabled", ALL);
    chk_rd("rd_data0", 0, 1);
    chk_rd("rd_data4_trunc", 4, 5);
    chk_rd("rd_data5", 5, 6);
    wr(6, 32'h77);
    chk_rd("rd_data6_absent", 6, 0);
    wr(13, 32'hFF);
    chk_rd("rd_reserved13", 13, 0);
    chk_rd("rd_ctrl", 10, 1);
    wr(9, 3);
    wr(8, 3);
    chk_rd("rd_mask", 8, 3);
    chk_rd("rd_period", 9, 3);
    wr(10, 3);
    for (int k = 0; k < 12; k++) begin
      exp_out($sformatf("blink_k%0d", k), ((k / 4) % 2) ? BLK : ALL);
      exp_irq("blink_irq_masked", 0);
      tick();
    end
    exp_out("blink_k12", BLK);
    wr(10, 1);
    exp_out("blink_off_out", ALL);
    chk_rd("blink_off_status", 11, 2);
    wr(11, 2);
    chk_rd("pend_clear", 11, 0);
    wr(9, 0);
    wr(10, 3);
    for (int k = 0; k < 10; k++) begin
      exp_out("period0_no_blink", ALL);
      tick();
    end
    chk_rd("period0_status", 11, 0);
    wr(10, 1);
    wr(9, 1);
    wr(10, 7);
    exp_irq("irq_e0", 0);
    tick();
    exp_irq("irq_e1", 0);
    tick();
    exp_irq("irq_e2", 1);
    exp_out("irq_phase_out", BLK);
    wr(11, 2);
    exp_irq("irq_cleared", 0);
    wr(11, 2);
    exp_irq("irq_set_wins", 1);
    chk_rd("set_wins_status", 11, 2);
    wr(10, 1);
    wr(11, 2);
    wr(9, 10);
    wr(10, 3);
    for (int k = 0; k < 8; k++) begin
      exp_out("p10_no_toggle", ALL);
      tick();
    end
    wr(9, 2);
    exp_out("rewrite_e0", ALL);
    tick();
    exp_out("rewrite_e1", ALL);
    tick();
    exp_out("rewrite_e2", ALL);
    tick();
    exp_out("rewrite_e3_toggle", BLK);
    chk_rd("rewrite_status", 11, 3);
    wr(0, 32'h3F);
    address = 11;
    reset = 1;
    #1;
    total++;
    if (irq === 1'b0) passed++;
    else $display("FAIL async_reset_irq_direct: got %0h expected 0", irq);
    exp_out("async_reset_out", 0);
    exp_irq("async_reset_irq", 0);
    q.push_back('{"async_reset_status", 0, 64'(0)});
    tick();
    reset = 0;
    for (int a = 0; a < 16; a++) chk_rd($sformatf("post_reset_rd%0d", a), 4'(a), 0);
    exp_out("post_reset_out", 0);
    tick(); tick();
    while (q.size() != 0) begin
      it = q.pop_front();
      total++;
      $display("FAIL %s: never compared, expected %0h", it.name, it.exp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
